// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic block set (multiplier / divider).
package arith_pkg;

  localparam int unsigned ARITH_WIDTH = 32;
  localparam int unsigned ARITH_CNT_W = $clog2(ARITH_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] trial;
  logic           ge;

  // A set top bit in R means the shifted value already exceeds any divisor.
  always_comb begin
    trial   = {r_i[WIDTH-1:0], q_msb_i};
    ge      = r_i[WIDTH] || (trial >= {1'b0, divisor_i});
    r_o     = ge ? (trial - {1'b0, divisor_i}) : trial;
    q_bit_o = ge;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative 2W/W unsigned restoring divider, one quotient bit per clock,
// with start/done handshake and divide-by-zero / quotient-overflow flags.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic               ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   r_d;
  logic             q_bit;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] dividend_hi;
  logic [WIDTH-1:0] dividend_lo;

  assign dividend_hi = dividend[2*WIDTH-1:WIDTH];
  assign dividend_lo = dividend[WIDTH-1:0];

  // Combinational datapath for the current iteration.
  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .r_o       (r_d),
    .q_bit_o   (q_bit)
  );

  assign q_d = {q_q[WIDTH-2:0], q_bit};

  // Control FSM and all result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            divisor_q <= divisor;
            busy_q    <= 1'b1;
            if (divisor == '0) begin
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
              quotient_q  <= '1;
              remainder_q <= dividend_lo;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else if (dividend_hi >= divisor) begin
              dbz_q       <= 1'b0;
              ovf_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= '0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b0;
              r_q     <= {1'b0, dividend_hi};
              q_q     <= dividend_lo;
              cnt_q   <= '0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quotient_q  <= q_d;
            remainder_q <= r_d[WIDTH-1:0];
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_seq_restoring_divider;

  localparam int unsigned W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           dbz;
  logic           ovf;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           e0;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   busy_run = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: track busy run length and score every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else      busy_run = 0;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done pulse with empty scoreboard (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("quotient",  64'(quotient),  64'(e.q));
          chk("remainder", 64'(remainder), 64'(e.r));
          chk("dbz",       64'(dbz),       64'(e.dbz));
          chk("ovf",       64'(ovf),       64'(e.ovf));
          chk("latency",   64'(cyc - e.e0), 64'(e.lat));
          chk("busy_len",  64'(busy_run),   64'(e.lat + 1));
        end
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic edbz, input logic eovf, input int e0);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = edbz;
    e.ovf = eovf;
    e.e0  = e0;
    e.lat = (edbz || eovf) ? 0 : int'(W);
    sb.push_back(e);
  endtask

  // Bounded wait for done, sampled on negedges.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
  endtask

  // Issue one operation from a negedge in IDLE and wait until it finishes.
  task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input logic eovf);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(eq, er, edbz, eovf, cyc);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    logic [2*W-1:0] rd;
    logic [W-1:0]   rv;
    logic [W-1:0]   rh;
    logic [2*W-1:0] mq;
    logic [2*W-1:0] mr;
    bit             spin;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_quotient",  64'(quotient),  64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz_ovf",   64'({dbz, ovf}), 64'd0);

    // Directed vectors with hand-computed results.
    run_op(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    run_op(64'h0000_0001_0000_0000, 32'd3, 32'h5555_5555, 32'd1, 1'b0, 1'b0);
    run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(64'h0000_0000_FFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(64'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(64'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
    run_op(64'h5_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    run_op(64'hFFFF_FFFF_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Start held high with operands churning: only the captured pair counts,
    // and the next start is taken only once the divider is back in IDLE.
    start    = 1'b1;
    dividend = 64'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    push_exp(32'd14, 32'd2, 1'b0, 1'b0, cyc);
    spin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        spin = 1'b1;
        break;
      end
      dividend = {$urandom, $urandom};
      divisor  = $urandom;
    end
    if (!spin) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout: got no done expected done within 200 cycles");
    end
    dividend = 64'd50;
    divisor  = 32'd5;
    push_exp(32'd10, 32'd0, 1'b0, 1'b0, cyc + 2);
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset in the middle of an operation: abandon it, no done pulse.
    start    = 1'b1;
    dividend = 64'd1000;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy",      64'(busy),      64'd0);
    chk("midrst_done",      64'(done),      64'd0);
    chk("midrst_quotient",  64'(quotient),  64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_dbz_ovf",   64'({dbz, ovf}), 64'd0);
    repeat (W + 5) @(negedge clk);
    run_op(64'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0);

    // Random pairs against a 64-bit reference model.
    for (int n = 0; n < 200; n++) begin
      rv = $urandom;
      if (rv == '0) rv = 32'd1;
      rh = $urandom;
      if (n % 4 == 0) rh = rv - 32'd1;
      if (rh >= rv) rh = rh % rv;
      rd = {rh, 32'($urandom)};
      mq = rd / {32'd0, rv};
      mr = rd % {32'd0, rv};
      run_op(rd, rv, mq[W-1:0], mr[W-1:0], 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
